// File: rtl/mem_arbiter_ctrl.sv
// Arbiter and byte sequencer that shares the synchronous byte-wide RAM between
// instruction fetch (32-bit reads) and the load/store unit (1/2/4-byte accesses).
module mem_arbiter_ctrl #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rstn_in,
    input  logic                  if_req_in,
    input  logic [31:0]           if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  lsu_req_in,
    input  logic                  lsu_wr_in,
    input  logic [1:0]            lsu_size_in,
    input  logic [31:0]           lsu_addr_in,
    input  logic [31:0]           lsu_wdata_in,
    output logic                  lsu_done_out,
    output logic [31:0]           lsu_rdata_out,
    output logic                  ram_en_out,
    output logic                  ram_r_nw_out,
    output logic [ADDR_WIDTH-1:0] ram_a_out,
    output logic [7:0]            ram_d_out,
    input  logic [7:0]            ram_q_in
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rbuf_q, rbuf_d;
    logic                  owner_lsu_q, owner_lsu_d;
    logic                  last_lsu_q, last_lsu_d;

    logic                  if_done_q, if_done_d;
    logic [31:0]           if_data_q, if_data_d;
    logic                  lsu_done_q, lsu_done_d;
    logic [31:0]           lsu_rdata_q, lsu_rdata_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_r_nw_q, ram_r_nw_d;
    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic [7:0]            ram_d_q, ram_d_d;

    logic                  grant_lsu;
    logic [2:0]            lsu_len;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [1:0]            next_lane;
    logic [1:0]            cap_lane;
    logic                  unused_addr_bits;

    // On a tie the requester that did not win last time is served.
    assign grant_lsu = lsu_req_in && (!if_req_in || !last_lsu_q);
    assign lsu_len   = (lsu_size_in == 2'b00) ? 3'd1 :
                       (lsu_size_in == 2'b01) ? 3'd2 : 3'd4;
    assign next_addr = base_q + ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
    assign next_lane = cnt_q[1:0] + 2'd1;
    // The byte captured now was addressed one cycle earlier.
    assign cap_lane  = cnt_q[1:0] - 2'd1;

    assign unused_addr_bits = ^{if_addr_in[31:ADDR_WIDTH], lsu_addr_in[31:ADDR_WIDTH]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        owner_lsu_d = owner_lsu_q;
        last_lsu_d  = last_lsu_q;
        if_done_d   = 1'b0;
        if_data_d   = if_data_q;
        lsu_done_d  = 1'b0;
        lsu_rdata_d = lsu_rdata_q;
        ram_en_d    = 1'b0;
        ram_r_nw_d  = 1'b1;
        ram_a_d     = ram_a_q;
        ram_d_d     = ram_d_q;

        case (state_q)
            IDLE: begin
                if (if_req_in || lsu_req_in) begin
                    owner_lsu_d = grant_lsu;
                    last_lsu_d  = grant_lsu;
                    base_d      = grant_lsu ? lsu_addr_in[ADDR_WIDTH-1:0]
                                            : if_addr_in[ADDR_WIDTH-1:0];
                    len_d       = grant_lsu ? lsu_len : 3'd4;
                    wdata_d     = grant_lsu ? lsu_wdata_in : 32'h0;
                    rbuf_d      = 32'h0;
                    cnt_d       = 3'd0;
                    ram_en_d    = 1'b1;
                    ram_a_d     = base_d;
                    if (grant_lsu && lsu_wr_in) begin
                        state_d    = WR;
                        ram_r_nw_d = 1'b0;
                        ram_d_d    = lsu_wdata_in[7:0];
                    end else begin
                        state_d = RD;
                    end
                end
            end

            RD: begin
                if (cnt_q != 3'd0) begin
                    rbuf_d[{cap_lane, 3'b000} +: 8] = ram_q_in;
                end
                if (cnt_q == len_q) begin
                    state_d = DONE;
                    if (owner_lsu_q) begin
                        lsu_done_d  = 1'b1;
                        lsu_rdata_d = rbuf_d;
                    end else begin
                        if_done_d = 1'b1;
                        if_data_d = rbuf_d;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d != len_q) begin
                        ram_en_d = 1'b1;
                        ram_a_d  = next_addr;
                    end
                end
            end

            WR: begin
                if (cnt_q + 3'd1 == len_q) begin
                    state_d    = DONE;
                    lsu_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 3'd1;
                    ram_en_d   = 1'b1;
                    ram_r_nw_d = 1'b0;
                    ram_a_d    = next_addr;
                    ram_d_d    = wdata_q[{next_lane, 3'b000} +: 8];
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            base_q      <= '0;
            wdata_q     <= 32'h0;
            rbuf_q      <= 32'h0;
            owner_lsu_q <= 1'b0;
            last_lsu_q  <= 1'b0;
            if_done_q   <= 1'b0;
            if_data_q   <= 32'h0;
            lsu_done_q  <= 1'b0;
            lsu_rdata_q <= 32'h0;
            ram_en_q    <= 1'b0;
            ram_r_nw_q  <= 1'b1;
            ram_a_q     <= '0;
            ram_d_q     <= 8'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            owner_lsu_q <= owner_lsu_d;
            last_lsu_q  <= last_lsu_d;
            if_done_q   <= if_done_d;
            if_data_q   <= if_data_d;
            lsu_done_q  <= lsu_done_d;
            lsu_rdata_q <= lsu_rdata_d;
            ram_en_q    <= ram_en_d;
            ram_r_nw_q  <= ram_r_nw_d;
            ram_a_q     <= ram_a_d;
            ram_d_q     <= ram_d_d;
        end
    end

    assign if_done_out   = if_done_q;
    assign if_data_out   = if_data_q;
    assign lsu_done_out  = lsu_done_q;
    assign lsu_rdata_out = lsu_rdata_q;
    assign ram_en_out    = ram_en_q;
    assign ram_r_nw_out  = ram_r_nw_q;
    assign ram_a_out     = ram_a_q;
    assign ram_d_out     = ram_d_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Randomised scoreboard bench for mem_arbiter_ctrl with a transaction-level
// arbitration/latency model and a behavioural byte RAM.
module tb_mem_arbiter_ctrl;

    localparam int AW       = 17;
    localparam int MEM_SIZE = 1 << AW;

    logic          clk_in  = 1'b0;
    logic          rstn_in = 1'b0;
    logic          if_req_in = 1'b0;
    logic [31:0]   if_addr_in = 32'h0;
    logic          if_done_out;
    logic [31:0]   if_data_out;
    logic          lsu_req_in = 1'b0;
    logic          lsu_wr_in = 1'b0;
    logic [1:0]    lsu_size_in = 2'b00;
    logic [31:0]   lsu_addr_in = 32'h0;
    logic [31:0]   lsu_wdata_in = 32'h0;
    logic          lsu_done_out;
    logic [31:0]   lsu_rdata_out;
    logic          ram_en_out;
    logic          ram_r_nw_out;
    logic [AW-1:0] ram_a_out;
    logic [7:0]    ram_d_out;
    logic [7:0]    ram_q_in = 8'h0;

    mem_arbiter_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_in        (clk_in),
        .rstn_in       (rstn_in),
        .if_req_in     (if_req_in),
        .if_addr_in    (if_addr_in),
        .if_done_out   (if_done_out),
        .if_data_out   (if_data_out),
        .lsu_req_in    (lsu_req_in),
        .lsu_wr_in     (lsu_wr_in),
        .lsu_size_in   (lsu_size_in),
        .lsu_addr_in   (lsu_addr_in),
        .lsu_wdata_in  (lsu_wdata_in),
        .lsu_done_out  (lsu_done_out),
        .lsu_rdata_out (lsu_rdata_out),
        .ram_en_out    (ram_en_out),
        .ram_r_nw_out  (ram_r_nw_out),
        .ram_a_out     (ram_a_out),
        .ram_d_out     (ram_d_out),
        .ram_q_in      (ram_q_in)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Physical RAM driven by the DUT, and the image the model says it should hold.
    logic [7:0] ram_mem [MEM_SIZE];
    logic [7:0] ref_mem [MEM_SIZE];

    always @(posedge clk_in) begin
        if (ram_en_out) begin
            if (ram_r_nw_out) ram_q_in <= ram_mem[ram_a_out];
            else              ram_mem[ram_a_out] <= ram_d_out;
        end
    end

    typedef struct {
        logic [31:0] data;
        bit          is_read;
        int          done_cyc;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        bit            rnw;
        logic [7:0]    d;
    } acc_t;

    exp_t if_q[$];
    exp_t lsu_q[$];
    acc_t acc_log[$];
    acc_t exp_log[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   last_lsu   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    function automatic int lenOf(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] addr, input int n);
        logic [31:0]   v = 32'h0;
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr[AW-1:0] + AW'(i);
            v[8*i +: 8] = ref_mem[a];
        end
        return v;
    endfunction

    task automatic refWrite(input logic [31:0] addr, input int n, input logic [31:0] wd);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr[AW-1:0] + AW'(i);
            ref_mem[a] = wd[8*i +: 8];
        end
    endtask

    // Scoreboard monitor: pops an expectation whenever a done pulse appears.
    bit   prev_done = 1'b0;
    exp_t mon_e;
    always @(negedge clk_in) begin
        if (rstn_in) begin
            if (prev_done) checkOutput("ram_en_idle_after_done", 32'(ram_en_out), 32'h0);
            if (if_done_out || lsu_done_out) begin
                checkOutput("ram_en_in_done", 32'(ram_en_out), 32'h0);
                checkOutput("done_exclusive", 32'(if_done_out && lsu_done_out), 32'h0);
            end
            if (if_done_out) begin
                if (if_q.size() == 0) begin
                    checkOutput("if_unexpected_done", 32'h1, 32'h0);
                end else begin
                    mon_e = if_q.pop_front();
                    checkOutput("if_data", if_data_out, mon_e.data);
                    checkOutput("if_done_cycle", cyc, mon_e.done_cyc);
                end
            end
            if (lsu_done_out) begin
                if (lsu_q.size() == 0) begin
                    checkOutput("lsu_unexpected_done", 32'h1, 32'h0);
                end else begin
                    mon_e = lsu_q.pop_front();
                    if (mon_e.is_read) checkOutput("lsu_rdata", lsu_rdata_out, mon_e.data);
                    checkOutput("lsu_done_cycle", cyc, mon_e.done_cyc);
                end
            end
            if (ram_en_out) acc_log.push_back('{addr: ram_a_out, rnw: ram_r_nw_out, d: ram_d_out});
            prev_done = if_done_out || lsu_done_out;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic waitDone(input int n_if, input int n_lsu);
        int li     = n_if;
        int ll     = n_lsu;
        int budget = 100;
        while ((li > 0 || ll > 0) && budget > 0) begin
            @(negedge clk_in);
            budget--;
            if (if_done_out && li > 0) begin
                li--;
                if (li == 0) if_req_in = 1'b0;
            end
            if (lsu_done_out && ll > 0) begin
                ll--;
                if (ll == 0) lsu_req_in = 1'b0;
            end
        end
        if (li > 0 || ll > 0) begin
            checkOutput("wait_timeout", 32'h1, 32'h0);
            if_req_in  = 1'b0;
            lsu_req_in = 1'b0;
            if_q.delete();
            lsu_q.delete();
        end
    endtask

    // Issues a round (each requester repeats its request n times while holding req)
    // and predicts the grant order and done cycles at transaction level.
    task automatic applyStimulus(input int n_if, input logic [31:0] ia,
                                 input int n_lsu, input bit wr, input logic [1:0] sz,
                                 input logic [31:0] la, input logic [31:0] wd);
        int   t, left_if, left_lsu, n;
        bit   pick_lsu;
        exp_t e;
        @(negedge clk_in);
        acc_log.delete();
        if_addr_in   = ia;
        lsu_wr_in    = wr;
        lsu_size_in  = sz;
        lsu_addr_in  = la;
        lsu_wdata_in = wd;
        if_req_in    = (n_if > 0);
        lsu_req_in   = (n_lsu > 0);
        t        = cyc;
        left_if  = n_if;
        left_lsu = n_lsu;
        while (left_if > 0 || left_lsu > 0) begin
            pick_lsu = (left_if > 0 && left_lsu > 0) ? !last_lsu : (left_lsu > 0);
            if (pick_lsu) begin
                n         = lenOf(sz);
                e.is_read = !wr;
                e.data    = wr ? 32'h0 : refRead(la, n);
                if (wr) refWrite(la, n, wd);
                e.done_cyc = t + (wr ? n + 1 : n + 2);
                lsu_q.push_back(e);
                left_lsu--;
            end else begin
                e.is_read  = 1'b1;
                e.data     = refRead(ia, 4);
                e.done_cyc = t + 6;
                if_q.push_back(e);
                left_if--;
            end
            last_lsu = pick_lsu;
            t = e.done_cyc + 1;
        end
        waitDone(n_if, n_lsu);
    endtask

    task automatic checkAccessLog(input string name);
        checkOutput({name, "_count"}, acc_log.size(), exp_log.size());
        for (int i = 0; i < acc_log.size() && i < exp_log.size(); i++) begin
            checkOutput({name, "_addr"}, 32'(acc_log[i].addr), 32'(exp_log[i].addr));
            checkOutput({name, "_rnw"}, 32'(acc_log[i].rnw), 32'(exp_log[i].rnw));
            if (!exp_log[i].rnw) checkOutput({name, "_wbyte"}, 32'(acc_log[i].d), 32'(exp_log[i].d));
        end
        exp_log.delete();
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_ram_en"}, 32'(ram_en_out), 32'h0);
        checkOutput({name, "_ram_r_nw"}, 32'(ram_r_nw_out), 32'h1);
        checkOutput({name, "_ram_a"}, 32'(ram_a_out), 32'h0);
        checkOutput({name, "_ram_d"}, 32'(ram_d_out), 32'h0);
        checkOutput({name, "_if_done"}, 32'(if_done_out), 32'h0);
        checkOutput({name, "_if_data"}, if_data_out, 32'h0);
        checkOutput({name, "_lsu_done"}, 32'(lsu_done_out), 32'h0);
        checkOutput({name, "_lsu_rdata"}, lsu_rdata_out, 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ia, la, wd, w5;
        logic [7:0]  pre [4];
        int          n_if, n_lsu, diffs;

        for (int i = 0; i < MEM_SIZE; i++) begin
            ram_mem[i] = 8'(i * 7 + (i >> 8) * 13 + 1);
            ref_mem[i] = ram_mem[i];
        end
        pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33; pre[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            ram_mem[32'h100 + i] = pre[i];
            ref_mem[32'h100 + i] = pre[i];
        end

        repeat (2) @(negedge clk_in);
        #1;
        checkResetOutputs("reset");
        @(negedge clk_in);
        rstn_in = 1'b1;

        // Simultaneous requests after reset: LSU first; LSU holds req so the next tie goes to IF.
        applyStimulus(1, 32'h0000_0300, 2, 1'b0, 2'b00, 32'h0001_0010, 32'h0);

        // Word fetch of a preloaded location.
        exp_log.delete();
        for (int i = 0; i < 4; i++) exp_log.push_back('{addr: AW'(32'h100 + i), rnw: 1'b1, d: 8'h0});
        applyStimulus(1, 32'h0000_0100, 0, 1'b0, 2'b00, 32'h0, 32'h0);
        checkAccessLog("fetch_0x100");

        // Halfword write then word read back.
        exp_log.push_back('{addr: AW'(32'h20), rnw: 1'b0, d: 8'hDD});
        exp_log.push_back('{addr: AW'(32'h21), rnw: 1'b0, d: 8'hCC});
        applyStimulus(0, 32'h0, 1, 1'b1, 2'b01, 32'h0000_0020, 32'hAABB_CCDD);
        checkAccessLog("half_write");
        applyStimulus(0, 32'h0, 1, 1'b0, 2'b10, 32'h0000_0020, 32'h0);

        // Word read across the top of the address space.
        exp_log.push_back('{addr: AW'(32'h1FFFE), rnw: 1'b1, d: 8'h0});
        exp_log.push_back('{addr: AW'(32'h1FFFF), rnw: 1'b1, d: 8'h0});
        exp_log.push_back('{addr: AW'(32'h00000), rnw: 1'b1, d: 8'h0});
        exp_log.push_back('{addr: AW'(32'h00001), rnw: 1'b1, d: 8'h0});
        applyStimulus(0, 32'h0, 1, 1'b0, 2'b11, 32'h0001_FFFE, 32'h0);
        checkAccessLog("wrap_read");

        // IF keeps req high through done: a second fetch follows.
        applyStimulus(2, 32'hFFFE_0200, 0, 1'b0, 2'b00, 32'h0, 32'h0);

        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
            n_if  = $urandom_range(0, 2);
            n_lsu = $urandom_range(0, 2);
            if (n_if == 0 && n_lsu == 0) n_if = 1;
            ia = ($urandom & 32'hFFFE_0000) | $urandom_range(32'h100, 32'hFF00);
            la = ($urandom & 32'hFFFE_0000) | $urandom_range(32'h10000, 32'h1FFFF);
            wd = $urandom;
            applyStimulus(n_if, ia, n_lsu, 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), la, wd);
        end

        // Reset during the third byte of a word write.
        @(negedge clk_in);
        w5           = $urandom;
        lsu_addr_in  = 32'h0001_0040;
        lsu_wdata_in = w5;
        lsu_wr_in    = 1'b1;
        lsu_size_in  = 2'b10;
        lsu_req_in   = 1'b1;
        repeat (3) @(negedge clk_in);
        rstn_in = 1'b0;
        #1;
        checkResetOutputs("abort");
        lsu_req_in = 1'b0;
        refWrite(32'h0001_0040, 2, w5);
        last_lsu = 1'b0;
        repeat (2) @(negedge clk_in);
        rstn_in = 1'b1;
        applyStimulus(0, 32'h0, 1, 1'b0, 2'b10, 32'h0001_0040, 32'h0);

        repeat (4) @(negedge clk_in);
        checkOutput("if_queue_drained", if_q.size(), 32'h0);
        checkOutput("lsu_queue_drained", lsu_q.size(), 32'h0);
        diffs = 0;
        for (int i = 0; i < MEM_SIZE; i++) if (ram_mem[i] !== ref_mem[i]) diffs++;
        checkOutput("ram_image_diff_bytes", diffs, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
